// File: rtl/sram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_stream_reader_if
// Description : Control, SRAM pin and output-stream bundle for the SRAM
//               stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_stream_reader_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              busy;
    logic              done;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, base_addr, num_words, sram_q, out_ready,
        output busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid
    );

    modport slave (
        output start, base_addr, num_words, sram_q, out_ready,
        input  busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : sram_stream_reader
// Description : Walks a contiguous SRAM address range and streams the words
//               out over valid/ready through a 2-entry skid FIFO.
//               Optional macro SRAM_RD_STALL_CNT_EN adds a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_stream_reader #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 11
) (
    input  wire logic            clk,
    input  wire logic            reset,
    sram_stream_reader_if.master bus
`ifdef SRAM_RD_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [1:0]        c_idle     = 2'd0;
    localparam logic [1:0]        c_run      = 2'd1;
    localparam logic [1:0]        c_drain    = 2'd2;
    localparam logic [1:0]        c_done     = 2'd3;
    localparam logic [ADDR_W-1:0] c_addr_inc = 1;
    localparam logic [ADDR_W:0]   c_rem_one  = 1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_inflight;
    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;

    logic       w_pop;
    logic       w_cap;
    logic       w_issue;
    logic       w_drained;
    logic [2:0] w_pending;

    assign w_pop     = (r_occ != 2'd0) && bus.out_ready;
    assign w_cap     = r_inflight;
    // Words that will be held or in flight after this cycle's pop; a new read
    // may only be issued if it still fits in the two buffer entries.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == c_run) && (r_remain != '0) && (w_pending < 3'd2);
    // Leave DRAIN on the cycle of the last handshake so done follows it directly.
    assign w_drained = !r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    assign bus.sram_cen  = ~w_issue;
    assign bus.sram_wen  = 1'b1;
    assign bus.sram_a    = r_addr;
    assign bus.out_data  = r_head;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.busy      = (r_state == c_run) || (r_state == c_drain);
    assign bus.done      = (r_state == c_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_remain <= bus.num_words;
                        r_state  <= (bus.num_words == '0) ? c_done : c_run;
                    end
                end
                c_run: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + c_addr_inc;
                        r_remain <= r_remain - c_rem_one;
                        if (r_remain == c_rem_one) begin
                            r_state <= c_drain;
                        end
                    end
                end
                c_drain: begin
                    if (w_drained) begin
                        r_state <= c_done;
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Head entry drives the stream; tail only fills while the head is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_cap, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= bus.sram_q;
                    end else begin
                        r_tail <= bus.sram_q;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= bus.sram_q;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= bus.sram_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRAM_RD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == c_idle) && bus.start) begin
            r_stall_cnt <= 32'd0;
        end else if (bus.out_valid && !bus.out_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_stream_reader
// Description : Table-driven self-checking bench for sram_stream_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int BUDGET = 3000;

    typedef struct {
        int          base;
        int          num;
        logic [31:0] rmask;     // out_ready for cycle k is rmask[k % 32]
        int          poke;      // cycle at which a stray start is driven (-1: none)
        int          exp_done;  // expected done cycle relative to start (0: not checked)
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

`ifdef SRAM_RD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    sram_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master)
`ifdef SRAM_RD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] word_of(input int a);
        return {32'hC0DE_0000 | a, ~32'(a), 32'(a * 7 + 3), 32'(a)};
    endfunction

    // Registered-address SRAM: data for an address issued in one cycle is
    // present on sram_q for the whole next cycle.
    always @(posedge clk) begin
        if (!bus.sram_cen && bus.sram_wen) begin
            bus.sram_q <= word_of(int'(bus.sram_a));
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int  issued, got, done_cyc, max_out;
        logic prev_stall;
        logic [127:0] prev_data;
        issued = 0; got = 0; done_cyc = -1; max_out = 0;
        prev_stall = 1'b0; prev_data = '0;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(v.base);
        bus.num_words = (ADDR_W + 1)'(v.num);
        bus.out_ready = 1'b1;

        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (cyc == v.poke) begin
                bus.start     = 1'b1;
                bus.base_addr = ADDR_W'(500);
                bus.num_words = (ADDR_W + 1)'(1);
            end else begin
                bus.start = 1'b0;
            end
            bus.out_ready = v.rmask[cyc % 32];
            #1;
            if (!bus.sram_cen) begin
                chk("sram_wen", bus.sram_wen, 1'b1);
                chk("sram_a", bus.sram_a, (v.base + issued) % DEPTH);
                issued++;
            end
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_data", bus.out_data, word_of((v.base + got) % DEPTH));
                got++;
            end
            if (issued - got > max_out) max_out = issued - got;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.done) begin
                done_cyc = cyc;
                chk("busy_at_done", bus.busy, 1'b0);
                break;
            end
        end

        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles (base %0d num %0d)", BUDGET, v.base, v.num);
        end
        chk("words_out", got, v.num);
        chk("reads_issued", issued, v.num);
        chk("outstanding_le2", (max_out <= 2), 1'b1);
        if (v.exp_done > 0) begin
            chk("done_cycle", done_cyc, v.exp_done);
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("done_pulse", bus.done, 1'b0);
        chk("idle_valid", bus.out_valid, 1'b0);
    endtask

    vec_t vecs [7];

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{base: 5,    num: 4,    rmask: 32'hFFFF_FFFF, poke: -1, exp_done: 7};
        vecs[1] = '{base: 2046, num: 4,    rmask: 32'hFFFF_FFFF, poke: -1, exp_done: 7};
        vecs[2] = '{base: 300,  num: 0,    rmask: 32'hFFFF_FFFF, poke: -1, exp_done: 1};
        vecs[3] = '{base: 100,  num: 6,    rmask: 32'hFFFF_FFFF, poke: 2,  exp_done: 9};
        vecs[4] = '{base: 40,   num: 8,    rmask: 32'hF6B0_6DB7, poke: -1, exp_done: 0};
        vecs[5] = '{base: 2045, num: 5,    rmask: 32'hAAAA_AAAA, poke: -1, exp_done: 0};
        vecs[6] = '{base: 7,    num: 2048, rmask: 32'hFFFF_FFFF, poke: -1, exp_done: 2051};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_cen", bus.sram_cen, 1'b1);
        chk("rst_wen", bus.sram_wen, 1'b1);
        chk("rst_a", bus.sram_a, '0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, '0);
        @(negedge clk);
        reset = 1'b0;

        // Reset two cycles into RUN, then a fresh transfer from a new base.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(10);
        bus.num_words = (ADDR_W + 1)'(8);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_cen", bus.sram_cen, 1'b1);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        run_xfer('{base: 20, num: 3, rmask: 32'hFFFF_FFFF, poke: -1, exp_done: 6});

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i]);
        end

        // Ready low during the first three valid cycles (3, 4, 5).
        run_xfer('{base: 60, num: 4, rmask: 32'hFFFF_FFC7, poke: -1, exp_done: 10});
`ifdef SRAM_RD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
